// File: rtl/sha256_kw_if.sv
// K+W word stream from the round-constant sequencer to the SHA-256 compression core.
interface sha256_kw_if;
    logic [31:0] kw_data;
    logic        kw_valid;
    logic        kw_ready;
    logic [5:0]  kw_round;
    logic        kw_last;

    modport master (output kw_data, kw_valid, kw_round, kw_last, input kw_ready);
    modport slave  (input kw_data, kw_valid, kw_round, kw_last, output kw_ready);
endinterface

// File: rtl/sha256_kw_sequencer.sv
// Expands one message block into W_0..W_63 and streams K_t + W_t to the
// compression core, addressing the combinational K ROM one round ahead.
module sha256_kw_sequencer #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [511:0]  block_in,
    output logic [5:0]    k_address,
    input  logic [31:0]   k_data,
    sha256_kw_if.master   kw,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

    localparam logic [6:0] LAST_T = 7'(NUM_ROUNDS - 1);

    state_e      state_q, state_d;
    logic [6:0]  t_q, t_d;
    logic [5:0]  k_address_q, k_address_d;
    logic [31:0] kw_data_q, kw_data_d;
    logic        kw_valid_q, kw_valid_d;
    logic [5:0]  kw_round_q, kw_round_d;
    logic        kw_last_q, kw_last_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] w_q [16];
    logic [31:0] w_d [16];
    logic        advance;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        t_d         = t_q;
        k_address_d = k_address_q;
        kw_data_d   = kw_data_q;
        kw_valid_d  = kw_valid_q;
        kw_round_d  = kw_round_q;
        kw_last_d   = kw_last_q;
        done_d      = 1'b0;
        w_d         = w_q;
        advance     = !kw_valid_q || kw.kw_ready;

        case (state_q)
            S_IDLE: begin
                // The done cycle still reads as IDLE; a start there must not launch a block.
                if (start && !done_q) begin
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = block_in[511 - 32*i -: 32];
                    end
                    t_d         = '0;
                    k_address_d = '0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (advance) begin
                    kw_data_d  = w_q[0] + k_data;
                    kw_round_d = t_q[5:0];
                    kw_last_d  = (t_q == LAST_T);
                    kw_valid_d = 1'b1;
                    for (int i = 0; i < 15; i++) begin
                        w_d[i] = w_q[i+1];
                    end
                    w_d[15]     = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];
                    t_d         = t_q + 7'd1;
                    k_address_d = t_d[5:0];
                    if (t_q == LAST_T) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (kw_valid_q && kw.kw_ready) begin
                    kw_valid_d = 1'b0;
                    kw_last_d  = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state is updated with <= so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            t_q         <= '0;
            k_address_q <= '0;
            kw_data_q   <= '0;
            kw_valid_q  <= 1'b0;
            kw_round_q  <= '0;
            kw_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            k_address_q <= k_address_d;
            kw_data_q   <= kw_data_d;
            kw_valid_q  <= kw_valid_d;
            kw_round_q  <= kw_round_d;
            kw_last_q   <= kw_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // NOTE: the window is fully reloaded at every start, so it carries no reset.
    always_ff @(posedge clk) begin
        w_q <= w_d;
    end

    assign k_address   = k_address_q;
    assign kw.kw_data  = kw_data_q;
    assign kw.kw_valid = kw_valid_q;
    assign kw.kw_round = kw_round_q;
    assign kw.kw_last  = kw_last_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule

// File: tb/tb_sha256_kw_sequencer.sv
// Bench for sha256_kw_sequencer: a message-schedule model checks every issued word
// under random backpressure, ignored starts, mid-block reset and a short round count.
module tb_sha256_kw_sequencer;
    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start, ready, sel20;
    logic [511:0] block_in;
    logic         start64, start20;
    logic [5:0]   k_addr64, k_addr20;
    logic [31:0]  k_data64, k_data20;
    logic         busy64, busy20, done64, done20;

    sha256_kw_if if64 ();
    sha256_kw_if if20 ();

    assign start64       = start & ~sel20;
    assign start20       = start & sel20;
    assign if64.kw_ready = ready;
    assign if20.kw_ready = ready;
    assign k_data64      = K_TAB[k_addr64];
    assign k_data20      = K_TAB[k_addr20];

    sha256_kw_sequencer #(.NUM_ROUNDS(64)) u_dut64 (
        .clk(clk), .reset(reset), .start(start64), .block_in(block_in),
        .k_address(k_addr64), .k_data(k_data64), .kw(if64), .busy(busy64), .done(done64)
    );

    sha256_kw_sequencer #(.NUM_ROUNDS(20)) u_dut20 (
        .clk(clk), .reset(reset), .start(start20), .block_in(block_in),
        .k_address(k_addr20), .k_data(k_data20), .kw(if20), .busy(busy20), .done(done20)
    );

    logic [31:0] o_data;
    logic [5:0]  o_round, o_kaddr;
    logic        o_valid, o_last, o_busy, o_done;

    always_comb begin
        if (sel20) begin
            o_data = if20.kw_data;  o_round = if20.kw_round; o_valid = if20.kw_valid;
            o_last = if20.kw_last;  o_kaddr = k_addr20;      o_busy  = busy20;  o_done = done20;
        end else begin
            o_data = if64.kw_data;  o_round = if64.kw_round; o_valid = if64.kw_valid;
            o_last = if64.kw_last;  o_kaddr = k_addr64;      o_busy  = busy64;  o_done = done64;
        end
    end

    int          checks = 0;
    int          errors = 0;
    int          n_acc;
    logic [31:0] exp_kw [64];
    logic [31:0] got [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Textbook message schedule: W_t from the block, then the recurrence over W_{t-16..t-2}.
    task automatic build_model(input logic [511:0] blk);
        logic [31:0] w [64];
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = blk[511 - 32*t -: 32];
            else        w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
            exp_kw[t] = w[t] + K_TAB[t];
        end
    endtask

    task automatic run_block(input int n, input bit rand_ready, input bit start_noise, input int abort_at);
        bit aborted;
        aborted = 1'b0;
        n_acc   = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        check("load_valid", o_valid, 0);
        check("load_busy", o_busy, 1);
        check("load_k_address", o_kaddr, 0);
        for (int cyc = 1; cyc < 1000 && n_acc < n; cyc++) begin
            @(negedge clk);
            if (start_noise) start = ($urandom_range(0, 3) == 0);
            check("kw_valid", o_valid, 1);
            check("kw_round", o_round, n_acc);
            check("kw_data", o_data, exp_kw[n_acc]);
            check("kw_last", o_last, (n_acc == n - 1));
            check("busy_run", o_busy, 1);
            check("done_run", o_done, 0);
            check("k_address", o_kaddr, (n_acc + 1) % 64);
            if (n_acc == abort_at) begin
                aborted = 1'b1;
                break;
            end
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ready) begin
                got[n_acc] = o_data;
                n_acc++;
            end
        end

        if (aborted) begin
            reset = 1'b1; start = 1'b0; ready = 1'b1;
            @(negedge clk); reset = 1'b0;
            check("abort_valid", o_valid, 0);
            check("abort_busy", o_busy, 0);
            check("abort_k_address", o_kaddr, 0);
            check("abort_done", o_done, 0);
            repeat (3) begin
                @(negedge clk);
                check("abort_no_done", o_done, 0);
                check("abort_idle_valid", o_valid, 0);
            end
        end else begin
            check("word_count", n_acc, n);
            @(negedge clk);
            start = start_noise;
            check("done_pulse", o_done, 1);
            check("done_valid", o_valid, 0);
            check("done_busy", o_busy, 0);
            check("done_last", o_last, 0);
            @(negedge clk); start = 1'b0;
            check("done_single", o_done, 0);
            repeat (3) begin
                @(negedge clk);
                check("idle_busy", o_busy, 0);
                check("idle_valid", o_valid, 0);
            end
        end
    endtask

    logic [511:0] abc_blk;

    initial begin
        abc_blk  = {32'h61626380, 448'h0, 32'h00000018};
        reset    = 1'b1;
        start    = 1'b0;
        ready    = 1'b0;
        sel20    = 1'b0;
        block_in = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_kw_data", o_data, 0);
        check("rst_k_address", o_kaddr, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_last", o_last, 0);
        reset = 1'b0;
        @(negedge clk);

        // "abc" block, always ready
        block_in = abc_blk;
        build_model(abc_blk);
        run_block(64, 1'b0, 1'b0, -1);
        check("abc_t0", got[0], 32'ha3ec9318);
        check("abc_t15", got[15], 32'hc19bf18c);
        check("abc_t16", got[16], 32'h45fdcd41);

        // all-zero block yields the bare constants
        block_in = '0;
        build_model('0);
        run_block(64, 1'b0, 1'b0, -1);
        check("zero_t0", got[0], 32'h428a2f98);
        check("zero_t63", got[63], 32'hc67178f2);

        // random backpressure on "abc"
        block_in = abc_blk;
        build_model(abc_blk);
        run_block(64, 1'b1, 1'b0, -1);
        check("bp_t16", got[16], 32'h45fdcd41);

        // starts during RUN and in the done cycle are ignored, then a fresh block
        block_in = '0;
        build_model('0);
        run_block(64, 1'b1, 1'b1, -1);
        block_in = abc_blk;
        build_model(abc_blk);
        run_block(64, 1'b0, 1'b0, -1);

        // reset at t=30, then a clean rerun of "abc"
        run_block(64, 1'b0, 1'b0, 30);
        run_block(64, 1'b0, 1'b0, -1);
        check("rerun_t0", got[0], 32'ha3ec9318);
        check("rerun_t63", got[63], exp_kw[63]);

        // short round count
        sel20 = 1'b1;
        run_block(20, 1'b0, 1'b0, -1);
        check("r20_k_address_idle", o_kaddr, 20);
        run_block(20, 1'b1, 1'b0, -1);
        check("r20_t19", got[19], exp_kw[19]);
        sel20 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sha256_kw_sequencer.md
Name: sha256_kw_sequencer

Overview:
- Consumer side of the SHA-256 round-constant ROM: drives the 6-bit ROM address and reads the 32-bit K word back in the same cycle (the ROM is purely combinational).
- Expands one 512-bit message block into the schedule W_0..W_63 with a 16-word shift window.
- Streams K_t + W_t, one word per round, to the compression core over a valid/ready handshake.
- Sits between the scrypt/PBKDF2 block loader and the SHA-256 compression round engine.

Parameters:
- NUM_ROUNDS, 64, number of rounds issued per block; legal range 17..64; the address counter is 7 bits internally.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  1-cycle request to begin a block; sampled only in IDLE
- block_in  input  512  message block; word 0 = block_in[511:480], word 15 = block_in[31:0]
- k_address  output  6  round-constant ROM address (registered)
- k_data  input  32  constant returned by the ROM for k_address, same cycle
- kw_data  output  32  K_t + W_t, mod 2^32
- kw_valid  output  1  kw_data/kw_round/kw_last are valid
- kw_ready  input  1  the core accepts the word this cycle
- kw_round  output  6  round index t of kw_data
- kw_last  output  1  marks t = NUM_ROUNDS-1
- busy  output  1  high in RUN and DRAIN
- done  output  1  1-cycle pulse after the last word is accepted

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; t = 0.
  - All outputs = 0, including k_address.
  - Window contents are don't-care.
  - Reset mid-block aborts immediately. No done pulse is produced and kw_valid drops on the next edge.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 loads window w[i] = block word i (i = 0..15), sets t = 0, k_address = 0, state -> RUN.
  - start is ignored in RUN and DRAIN. block_in is sampled only at start.
- RUN:
  - advance = !kw_valid || kw_ready.
  - On advance:
    - kw_data <= w[0] + k_data
    - kw_round <= t; kw_last <= (t == NUM_ROUNDS-1); kw_valid <= 1
    - window shifts: w[i] <= w[i+1] for i = 0..14, and w[15] <= σ1(w[14]) + w[9] + σ0(w[1]) + w[0]
    - t <= t+1; k_address <= t+1 (truncated to 6 bits)
  - No advance: every register holds (output stable under backpressure, no skipped or duplicated rounds).
  - On an advance with t == NUM_ROUNDS-1: state -> DRAIN.
- Schedule functions (all adds mod 2^32):
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10
- DRAIN:
  - When kw_valid && kw_ready: kw_valid <= 0, kw_last <= 0, done <= 1 for one cycle, state -> IDLE.
  - A start coinciding with the done cycle is ignored; start is accepted from the cycle after done.
- Latency:
  - First kw_valid appears 2 cycles after the start cycle (load edge, then the first advance edge).
  - With kw_ready held at 1: exactly NUM_ROUNDS consecutive valid cycles, and done follows the cycle after the last one.
- k_address always equals the t of the next word to be issued, so k_data is stable when it is consumed.
- kw_valid, once high, never drops until its word is accepted.

Test Plan:
1. Block "abc" (0x61626380, words 1-14 = 0, word 15 = 0x00000018), kw_ready=1 -> every cycle is valid:
   - t=0: kw_data 0xa3ec9318
   - t=15: 0xc19bf18c
   - t=16: 0x45fdcd41 (W16 = 0x61626380)
   - 64 words total, kw_last at t=63, done one cycle later
2. All-zero block -> kw_data = K_t on every round; t=0 gives 0x428a2f98, t=63 gives 0xc67178f2 with kw_last=1.
3. kw_ready toggling 1,0,0,1 pseudo-randomly on the "abc" block -> word sequence identical to scenario 1, no duplicates or gaps, kw_data stable while kw_ready=0.
4. start pulsed during RUN and in the done cycle -> ignored; the following block starts only after the next start seen in IDLE.
5. reset asserted at t=30 -> next cycle kw_valid=0, busy=0, k_address=0, no done; a new start then reproduces scenario 1 exactly.
6. NUM_ROUNDS=20, "abc" block -> 20 words, kw_last at t=19, done follows, k_address returns to 0 in IDLE after the next start.
